// File: rtl/tcdm_sched_pkg.sv
// Shared types for the TCDM bank scheduler: master index, response-pipe entry, lock FSM state.
// Every NumIn used with this package must be <= NumInMax, and $clog2(NumIn) must equal IdxWidth.
package tcdm_sched_pkg;

  localparam int unsigned NumInMax = 8;
  localparam int unsigned IdxWidth = $clog2(NumInMax);

  typedef logic [IdxWidth-1:0] idx_t;

  typedef struct packed {
    logic valid;
    idx_t idx;
  } resp_entry_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/tcdm_sched_resp_pipe.sv
// RespLat-deep delay line of {valid, idx}; the output lines up with the bank's read data.
module tcdm_sched_resp_pipe
  import tcdm_sched_pkg::*;
#(
  parameter int unsigned RespLat = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  resp_entry_t entry_i,
  output resp_entry_t entry_o
);

  resp_entry_t [RespLat-1:0] stage_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= entry_i;
      for (int s = 1; s < int'(RespLat); s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign entry_o = stage_q[RespLat-1];

endmodule

// File: rtl/tcdm_bank_sched.sv
// Round-robin + starvation-override arbiter for one single-ported TCDM bank, with response routing.
// Optional atomic lock support when TCDM_SCHED_LOCK_EN is defined (adds lock_i and the lock FSM).
module tcdm_bank_sched
  import tcdm_sched_pkg::*;
#(
  parameter int unsigned NumIn     = 8,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned BeWidth   = DataWidth / 8,
  parameter int unsigned RespLat   = 1,
  parameter int unsigned MaxWait   = 15
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumIn-1:0]               req_i,
  output logic [NumIn-1:0]               gnt_o,
  input  logic [NumIn*AddrWidth-1:0]     add_i,
  input  logic [NumIn-1:0]               wen_i,
  input  logic [NumIn*DataWidth-1:0]     wdata_i,
  input  logic [NumIn*BeWidth-1:0]       be_i,
`ifdef TCDM_SCHED_LOCK_EN
  input  logic [NumIn-1:0]               lock_i,
`endif
  output logic [NumIn-1:0]               rvalid_o,
  output logic [DataWidth-1:0]           rdata_o,
  output logic                           bank_req_o,
  input  logic                           bank_gnt_i,
  output logic [AddrWidth-1:0]           bank_add_o,
  output logic                           bank_wen_o,
  output logic [DataWidth-1:0]           bank_wdata_o,
  output logic [BeWidth-1:0]             bank_be_o,
  input  logic [DataWidth-1:0]           bank_rdata_i
);

  localparam int unsigned CntW    = $clog2(MaxWait + 1);
  localparam idx_t        LastIdx = idx_t'(NumIn - 1);

  logic [NumIn-1:0][AddrWidth-1:0] add_a;
  logic [NumIn-1:0][DataWidth-1:0] wdata_a;
  logic [NumIn-1:0][BeWidth-1:0]   be_a;
  assign add_a   = add_i;
  assign wdata_a = wdata_i;
  assign be_a    = be_i;

  idx_t                       rr_q, rr_d, rr_win, starve_win, winner;
  logic                       rr_found, starve_any, req_any, hs, lock_act;
  logic [NumIn-1:0][CntW-1:0] cnt_q, cnt_d;
  int unsigned                j;

  // Lowest-index starved requester; descending scan so the last hit is the lowest.
  always_comb begin
    starve_any = 1'b0;
    starve_win = '0;
    for (int i = int'(NumIn) - 1; i >= 0; i--) begin
      if (req_i[i] && cnt_q[i] == CntW'(MaxWait)) begin
        starve_any = 1'b1;
        starve_win = idx_t'(i);
      end
    end
  end

  always_comb begin
    rr_found = 1'b0;
    rr_win   = rr_q;
    j        = 0;
    for (int unsigned k = 0; k < NumIn; k++) begin
      j = 32'(rr_q) + k;
      if (j >= NumIn) j = j - NumIn;
      if (!rr_found && req_i[idx_t'(j)]) begin
        rr_found = 1'b1;
        rr_win   = idx_t'(j);
      end
    end
  end

`ifdef TCDM_SCHED_LOCK_EN
  lock_state_e state_q;
  idx_t        owner_q;

  // Lock only holds while the owner keeps both req and lock high; otherwise arbitrate normally this cycle.
  assign lock_act = (state_q == LOCKED) && req_i[owner_q] && lock_i[owner_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else if (lock_act) begin
      state_q <= LOCKED;
    end else if (hs && lock_i[winner]) begin
      state_q <= LOCKED;
      owner_q <= winner;
    end else begin
      state_q <= IDLE;
    end
  end

  assign winner = lock_act ? owner_q : (starve_any ? starve_win : rr_win);
`else
  assign lock_act = 1'b0;
  assign winner   = starve_any ? starve_win : rr_win;
`endif

  assign req_any      = (|req_i) & ~rst_i;
  assign hs           = req_any & bank_gnt_i;
  assign bank_req_o   = req_any;
  assign bank_add_o   = req_any ? add_a[winner]   : '0;
  assign bank_wdata_o = req_any ? wdata_a[winner] : '0;
  assign bank_be_o    = req_any ? be_a[winner]    : '0;
  assign bank_wen_o   = req_any & wen_i[winner];

  always_comb begin
    gnt_o = '0;
    if (hs) gnt_o[winner] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (hs && !lock_act) rr_d = (winner == LastIdx) ? '0 : winner + idx_t'(1);
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < int'(NumIn); i++) begin
      if (!req_i[i] || (hs && winner == idx_t'(i))) cnt_d[i] = '0;
      else if (cnt_q[i] != CntW'(MaxWait))         cnt_d[i] = cnt_q[i] + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
    end
  end

  resp_entry_t push, resp_q;
  assign push = '{valid: hs, idx: winner};

  tcdm_sched_resp_pipe #(.RespLat(RespLat)) i_resp_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .entry_i (push),
    .entry_o (resp_q)
  );

  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    if (resp_q.valid) begin
      rvalid_o[resp_q.idx] = 1'b1;
      rdata_o              = bank_rdata_i;
    end
  end

endmodule
